// File: rtl/angle_bcd_source.sv
// angle_bcd_source: selects one of three angles and converts it to four BCD digits
module angle_bcd_source #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  input  logic             change,
  output logic [3:0]       digit3,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0,
  output logic [1:0]       src,
  output logic             valid
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [1:0]       r_sel, r_tag;
  logic             r_change_q, w_edge;
  logic [WIDTH-1:0] r_bin, w_pick;
  logic [15:0]      r_bcd, w_adj;
  logic [3:0]       r_cnt;
  assign w_edge = change & ~r_change_q;
  assign w_pick = r_sel == 2'd0 ? R1 : r_sel == 2'd1 ? R2 : R3;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign w_adj[4*g+:4] = r_bcd[4*g+:4] >= 4'd5 ? r_bcd[4*g+:4] + 4'd3 : r_bcd[4*g+:4];
  end
  // button edge detection advances the selection 0->1->2->0
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_change_q <= 1'b1;
      r_sel      <= 2'd0;
    end else begin
      r_change_q <= change;
      if (w_edge) r_sel <= r_sel == 2'd2 ? 2'd0 : r_sel + 2'd1;
    end
  end
  // state register
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end
  // next state: one IDLE sample, WIDTH shifts, one DONE publish
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = SHIFT;
      SHIFT:   w_next = r_cnt == 4'(WIDTH - 1) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  // double-dabble datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_tag  <= 2'd0;
      digit3 <= 4'd0;
      digit2 <= 4'd0;
      digit1 <= 4'd0;
      digit0 <= 4'd0;
      src    <= 2'd0;
      valid  <= 1'b0;
    end else begin
      valid <= r_state == DONE;
      case (r_state)
        IDLE: begin
          r_bin <= w_pick;
          r_tag <= r_sel;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
        end
        default: begin
          {digit3, digit2, digit1, digit0} <= r_bcd;
          src                              <= r_tag;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_angle_bcd_source.sv
// tb_angle_bcd_source: randomized and directed checks against a cycle-level reference model
module tb_angle_bcd_source;
  localparam int W = 10;
  localparam int P = W + 2;
  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] R1 = '0, R2 = '0, R3 = '0;
  logic         change = 1'b0;
  logic [3:0]   digit3, digit2, digit1, digit0;
  logic [1:0]   src;
  logic         valid;
  int           passed = 0, total = 0;

  angle_bcd_source #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .R1(R1), .R2(R2), .R3(R3), .change(change),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .src(src), .valid(valid)
  );

  always #5 clock = ~clock;

  // reference model: free-running period of W+2 edges, sample at phase 0, publish decimal digits at the last phase
  int        m_phase;
  int        m_val;
  int        m_sel;
  int        m_tag;
  logic      m_chq;
  logic [15:0] exp_dig;
  logic [1:0]  exp_src;
  logic        exp_valid;
  always @(posedge clock) begin
    if (!resetn) begin
      m_phase   <= 0;
      m_sel     <= 0;
      m_chq     <= 1'b1;
      m_val     <= 0;
      m_tag     <= 0;
      exp_dig   <= '0;
      exp_src   <= '0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= m_phase == P - 1;
      if (m_phase == 0) begin
        m_val <= m_sel == 0 ? int'(R1) : m_sel == 1 ? int'(R2) : int'(R3);
        m_tag <= m_sel;
      end
      if (m_phase == P - 1) begin
        exp_dig <= {4'((m_val / 1000) % 10), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
        exp_src <= 2'(m_tag);
      end
      m_phase <= m_phase == P - 1 ? 0 : m_phase + 1;
      if (change && !m_chq) m_sel <= (m_sel + 1) % 3;
      m_chq <= change;
    end
  end

  task automatic test_reset();
    resetn = 1'b0; change = 1'b0; R1 = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({digit3, digit2, digit1, digit0, src, valid} !== 19'd0)
      $display("FAIL reset_state got=%h req=0", {digit3, digit2, digit1, digit0, src, valid});
    else passed++;
    resetn = 1'b1;
    begin
      int nv = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        nv += int'(valid);
        total++;
        if ({digit3, digit2, digit1, digit0, src, valid} !== {exp_dig, exp_src, exp_valid})
          $display("FAIL zero_run got=%h/%0d/%b req=%h/%0d/%b", {digit3, digit2, digit1, digit0}, src, valid, exp_dig, exp_src, exp_valid);
        else passed++;
      end
      total++;
      if (nv !== 2) $display("FAIL zero_valid_count got=%0d req=2", nv);
      else passed++;
    end
  endtask

  task automatic run_model(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      total++;
      if ({digit3, digit2, digit1, digit0, src, valid} !== {exp_dig, exp_src, exp_valid})
        $display("FAIL %s got=%h/%0d/%b req=%h/%0d/%b", name, {digit3, digit2, digit1, digit0}, src, valid, exp_dig, exp_src, exp_valid);
      else passed++;
    end
  endtask

  task automatic test_max();
    R1 = 10'd1023;
    run_model(2 * P, "max_run");
    total++;
    if ({digit3, digit2, digit1, digit0, src} !== {16'h1023, 2'd0})
      $display("FAIL max_value got=%h/%0d req=1023/0", {digit3, digit2, digit1, digit0}, src);
    else passed++;
    R1 = 10'd999;
    run_model(2 * P, "nines_run");
    total++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0999)
      $display("FAIL nines_value got=%h req=0999", {digit3, digit2, digit1, digit0});
    else passed++;
  endtask

  task automatic test_change_pulse();
    R2 = 10'd359;
    change = 1'b1;
    @(negedge clock);
    change = 1'b0;
    run_model(2 * P + 2, "pulse_run");
    total++;
    if ({digit3, digit2, digit1, digit0, src} !== {16'h0359, 2'd1})
      $display("FAIL pulse_value got=%h/%0d req=0359/1", {digit3, digit2, digit1, digit0}, src);
    else passed++;
  endtask

  task automatic test_hold();
    R3 = 10'd77;
    R1 = 10'd5;
    change = 1'b1;
    run_model(40, "hold_run");
    change = 1'b0;
    run_model(P + 2, "hold_after");
    for (int k = 0; k < 3; k++) begin
      change = 1'b1;
      run_model(1, "hold_pulse");
      change = 1'b0;
      run_model(2 * P, "hold_pulse_run");
    end
  endtask

  task automatic test_mid_conversion();
    resetn = 1'b0; change = 1'b0;
    R1 = 10'd512; R2 = 10'd45;
    @(negedge clock);
    resetn = 1'b1;
    run_model(4, "mid_pre");
    change = 1'b1;
    run_model(1, "mid_pulse");
    change = 1'b0;
    for (int n = 0; n < 2; n++) begin
      int i = 0;
      for (i = 0; i < 2 * P && !valid; i++) run_model(1, "mid_wait");
      total++;
      if (!valid) $display("FAIL mid_timeout got=0 req=1");
      else if (n == 0 && {digit3, digit2, digit1, digit0, src} !== {16'h0512, 2'd0})
        $display("FAIL mid_first got=%h/%0d req=0512/0", {digit3, digit2, digit1, digit0}, src);
      else if (n == 1 && {digit3, digit2, digit1, digit0, src} !== {16'h0045, 2'd1})
        $display("FAIL mid_second got=%h/%0d req=0045/1", {digit3, digit2, digit1, digit0}, src);
      else passed++;
      if (n == 0) run_model(1, "mid_gap");
    end
  endtask

  task automatic test_reset_mid();
    run_model(5, "rst_pre");
    resetn = 1'b0;
    @(negedge clock);
    total++;
    if ({digit3, digit2, digit1, digit0, src, valid} !== 19'd0)
      $display("FAIL rst_mid_state got=%h req=0", {digit3, digit2, digit1, digit0, src, valid});
    else passed++;
    resetn = 1'b1;
    begin
      int first = -1;
      for (int i = 1; i <= P; i++) begin
        run_model(1, "rst_post");
        if (valid && first < 0) first = i;
      end
      total++;
      if (first !== P) $display("FAIL rst_first_valid got=%0d req=%0d", first, P);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      R1 = W'($urandom_range(0, 1023));
      R2 = W'($urandom_range(0, 1023));
      R3 = W'($urandom_range(0, 1023));
      run_model($urandom_range(1, 15), "rand_run");
      change = $urandom_range(0, 1) == 1;
      run_model($urandom_range(1, 3), "rand_chg");
      change = 1'b0;
    end
    run_model(2 * P, "rand_tail");
  endtask

  initial begin
    test_reset();
    test_max();
    test_change_pulse();
    test_hold();
    test_mid_conversion();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
